step_pulse_shaper: RTL and testbench

//  Converts the single-cycle step/dir events from the acceleration profile generator into driver-legal

---
 rtl/step_pulse_shaper_if.sv | 32 +++
 rtl/step_pulse_shaper.sv | 155 +++++++++++++++
 tb/tb_step_pulse_shaper.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/step_pulse_shaper_if.sv
// Step/dir event inputs, pulse timing controls and pin/status outputs of the STEP/DIR pulse shaper.
// The master modport is the profile-generator side; the slave modport is the shaper itself.
interface step_pulse_shaper_if #(
    parameter int DEPTH = 4,
    parameter int TW    = 16,
    parameter int POS_W = 32
);
    localparam int AW = $clog2(DEPTH);

    logic                    step_in;
    logic                    dir_in;
    logic [TW-1:0]           dir_setup_len;
    logic [TW-1:0]           pulse_len;
    logic [TW-1:0]           low_len;
    logic                    err_clear;
    logic                    step_out;
    logic                    dir_out;
    logic signed [POS_W-1:0] position;
    logic [AW:0]             pending;
    logic                    busy;
    logic                    overflow;

    modport master (
        output step_in, dir_in, dir_setup_len, pulse_len, low_len, err_clear,
        input  step_out, dir_out, position, pending, busy, overflow
    );

    modport slave (
        input  step_in, dir_in, dir_setup_len, pulse_len, low_len, err_clear,
        output step_out, dir_out, position, pending, busy, overflow
    );
endinterface

// File: rtl/step_pulse_shaper.sv
// Turns queued single-cycle step events into STEP/DIR pin pulses with DIR setup, STEP high and low times.
// Step in -> STEP rise after the next edge when no reversal; a full FIFO drops the step and sets overflow.
module step_pulse_shaper #(
    parameter int DEPTH = 4,
    parameter int TW    = 16,
    parameter int POS_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    step_pulse_shaper_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]      FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]      CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);
    localparam logic [TW-1:0]    T_ONE   = TW'(1);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_LOW   = 2'd3;

    logic [1:0]       state_q,    state_d;
    logic [TW-1:0]    timer_q,    timer_d;
    logic             step_out_q, step_out_d;
    logic             dir_out_q,  dir_out_d;
    logic             overflow_q, overflow_d;
    logic [POS_W-1:0] pos_q,      pos_d;
    logic [DEPTH-1:0] fifo_q,     fifo_d;
    logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
    logic [AW:0]      count_q,    count_d;

    logic             pop;
    logic             push;
    logic             head;
    logic [POS_W-1:0] pos_step;

    // A programmed length of zero still occupies its state for one cycle.
    function automatic logic [TW-1:0] len_or_one(input logic [TW-1:0] len);
        return (len == '0) ? T_ONE : len;
    endfunction

    assign head     = fifo_q[rd_ptr_q];
    assign pos_step = dir_out_q ? POS_ONE : '1;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        step_out_d = step_out_q;
        dir_out_d  = dir_out_q;
        pos_d      = pos_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (head == dir_out_q) begin
                        step_out_d = 1'b1;
                        pos_d      = pos_q + pos_step;
                        state_d    = ST_HIGH;
                        timer_d    = len_or_one(bus.pulse_len);
                    end else begin
                        // DIR only ever moves here, so it is stable for the whole pulse and low time.
                        dir_out_d  = head;
                        state_d    = ST_SETUP;
                        timer_d    = len_or_one(bus.dir_setup_len);
                    end
                end
            end
            ST_SETUP: begin
                if (timer_q == T_ONE) begin
                    step_out_d = 1'b1;
                    pos_d      = pos_q + pos_step;
                    state_d    = ST_HIGH;
                    timer_d    = len_or_one(bus.pulse_len);
                end else begin
                    timer_d    = timer_q - T_ONE;
                end
            end
            ST_HIGH: begin
                if (timer_q == T_ONE) begin
                    step_out_d = 1'b0;
                    state_d    = ST_LOW;
                    timer_d    = len_or_one(bus.low_len);
                end else begin
                    timer_d    = timer_q - T_ONE;
                end
            end
            default: begin
                if (timer_q == T_ONE) begin
                    state_d    = ST_IDLE;
                end else begin
                    timer_d    = timer_q - T_ONE;
                end
            end
        endcase
    end

    always_comb begin
        push       = bus.step_in && ((count_q != FULL) || pop);
        overflow_d = overflow_q;
        if (bus.step_in && !push) begin
            overflow_d = 1'b1;
        end else if (bus.err_clear) begin
            overflow_d = 1'b0;
        end
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = bus.dir_in;
        end
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            step_out_q <= 1'b0;
            dir_out_q  <= 1'b0;
            overflow_q <= 1'b0;
            pos_q      <= '0;
            fifo_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            step_out_q <= step_out_d;
            dir_out_q  <= dir_out_d;
            overflow_q <= overflow_d;
            pos_q      <= pos_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign bus.step_out = step_out_q;
    assign bus.dir_out  = dir_out_q;
    assign bus.position = pos_q;
    assign bus.pending  = count_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = (state_q != ST_IDLE) || (count_q != '0);
endmodule

// File: tb/tb_step_pulse_shaper.sv
// Scoreboard bench for step_pulse_shaper: an edge-timeline model predicts each STEP pulse and the status
// outputs; a negedge monitor compares every pulse and every cycle's status against those predictions.
module tb_step_pulse_shaper;
    localparam int DEPTH = 4;
    localparam int TW    = 16;
    localparam int POS_W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    step_pulse_shaper_if #(.DEPTH(DEPTH), .TW(TW), .POS_W(POS_W)) bus();

    step_pulse_shaper #(.DEPTH(DEPTH), .TW(TW), .POS_W(POS_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                      rise;
        bit                      dir;
        logic signed [POS_W-1:0] pos;
        int                      hw;
    } pulse_t;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     free_at = 0;
    bit     rst_edge = 1'b0;
    bit     m_q[$];
    bit     m_dir = 1'b0;
    int     m_pos = 0;
    bit     m_ovf = 1'b0;
    pulse_t exp_q[$];

    bit     prev_step = 1'b0;
    bit     in_pulse = 1'b0;
    int     hi_start = 0;
    int     hi_exp = 0;

    function automatic int max1(input logic [TW-1:0] v);
        return (v == '0) ? 1 : int'(v);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference timeline: a step popped at edge n rises at n (or n+setup on a reversal), stays high for
    // the pulse time, low for the low time, and the next pop can happen one edge after LOW ends.
    always @(posedge clk) begin
        bit     d;
        int     rise;
        pulse_t p;
        cyc      = cyc + 1;
        rst_edge = reset;
        if (reset) begin
            m_q.delete();
            exp_q.delete();
            m_dir   = 1'b0;
            m_pos   = 0;
            m_ovf   = 1'b0;
            free_at = 0;
        end else begin
            if (cyc >= free_at && m_q.size() > 0) begin
                d     = m_q.pop_front();
                rise  = (d == m_dir) ? cyc : cyc + max1(bus.dir_setup_len);
                m_dir = d;
                m_pos = m_pos + (d ? 1 : -1);
                p.rise = rise;
                p.dir  = d;
                p.pos  = POS_W'(m_pos);
                p.hw   = max1(bus.pulse_len);
                exp_q.push_back(p);
                free_at = rise + max1(bus.pulse_len) + max1(bus.low_len) + 1;
            end
            if (bus.step_in && m_q.size() >= DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                if (bus.step_in) m_q.push_back(bus.dir_in);
                if (bus.err_clear) m_ovf = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        pulse_t e;
        if (rst_edge) begin
            check("reset_step_out", bus.step_out, 0);
            check("reset_dir_out",  bus.dir_out,  0);
            check("reset_position", bus.position, 0);
            check("reset_pending",  bus.pending,  0);
            check("reset_overflow", bus.overflow, 0);
            check("reset_busy",     bus.busy,     0);
            in_pulse  = 1'b0;
            prev_step = 1'b0;
        end else begin
            if (bus.step_out && !prev_step) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: step_out rose with no step predicted (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rise_cycle",    cyc,          e.rise);
                    check("rise_dir",      bus.dir_out,  e.dir);
                    check("rise_position", bus.position, e.pos);
                    hi_start = cyc;
                    hi_exp   = e.hw;
                    in_pulse = 1'b1;
                end
            end else if (!bus.step_out && prev_step && in_pulse) begin
                check("high_width", cyc - hi_start, hi_exp);
                in_pulse = 1'b0;
            end
            check("dir_out",  bus.dir_out,  m_dir);
            check("pending",  bus.pending,  m_q.size());
            check("overflow", bus.overflow, m_ovf);
            check("busy",     bus.busy,     (cyc < free_at - 1) || (m_q.size() != 0));
            prev_step = bus.step_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int s, input int p, input int l);
        bus.dir_setup_len = TW'(s);
        bus.pulse_len     = TW'(p);
        bus.low_len       = TW'(l);
    endtask

    task automatic send(input bit d, input bit clr);
        bus.step_in   = 1'b1;
        bus.dir_in    = d;
        bus.err_clear = clr;
        tick();
        bus.step_in   = 1'b0;
        bus.err_clear = 1'b0;
    endtask

    task automatic drain(input int max_cyc, input string name);
        int n = 0;
        while ((m_q.size() != 0 || exp_q.size() != 0 || in_pulse || cyc < free_at || bus.busy)
               && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (n >= max_cyc) begin
            errors++;
            $display("FAIL %s_drain: still busy after %0d cycles, expected idle", name, n);
        end
    endtask

    initial begin
        bus.step_in   = 1'b0;
        bus.dir_in    = 1'b0;
        bus.err_clear = 1'b0;
        set_len(0, 1, 1);
        tick();
        tick();
        reset = 1'b0;

        // Single -1 step, 3-cycle high, 2-cycle low.
        set_len(0, 3, 2);
        send(1'b0, 1'b0);
        drain(100, "t1");
        check("t1_position", bus.position, -1);

        // Reversal with a 5-cycle DIR setup.
        set_len(5, 1, 1);
        send(1'b1, 1'b0);
        drain(100, "t2");
        check("t2_dir_out", bus.dir_out, 1);
        check("t2_position", bus.position, 0);

        // Burst of six into a 4-deep FIFO behind a long pulse; err_clear loses to a same-cycle drop.
        set_len(1, 100, 1);
        for (int i = 0; i < 6; i++) send(1'b1, 1'b0);
        check("t3_overflow", bus.overflow, 1);
        check("t3_pending", bus.pending, 4);
        send(1'b1, 1'b1);
        check("t3_clear_vs_drop", bus.overflow, 1);
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;
        check("t3_clear", bus.overflow, 0);
        drain(1000, "t3");
        check("t3_position", bus.position, 5);

        // All lengths zero, alternating directions.
        set_len(0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            send(i % 2 == 1, 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain(200, "t4");
        check("t4_position", bus.position, 5);
        check("t4_dir_out", bus.dir_out, 1);

        // Reset in the middle of a pulse with three steps queued.
        set_len(1, 20, 2);
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
        check("t5_step_high", bus.step_out, 1);
        check("t5_pending", bus.pending, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (40) tick();
        check("t5_position", bus.position, 0);
        check("t5_busy", bus.busy, 0);

        // Walk position up to the positive limit, then wrap.
        set_len(0, 0, 0);
        for (int i = 0; i < 127; i++) begin
            send(1'b1, 1'b0);
            repeat (3) tick();
        end
        drain(100, "t6a");
        check("t6_max_position", bus.position, 127);
        send(1'b1, 1'b0);
        drain(100, "t6b");
        check("t6_wrap_position", bus.position, -128);

        // Random bursts with random timing, settled before each timing change.
        for (int b = 0; b < 8; b++) begin
            set_len($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            for (int c = 0; c < 150; c++) begin
                bus.step_in   = ($urandom_range(0, 2) == 0);
                bus.dir_in    = $urandom_range(0, 1) == 1;
                bus.err_clear = ($urandom_range(0, 15) == 0);
                tick();
            end
            bus.step_in   = 1'b0;
            bus.err_clear = 1'b0;
            drain(500, "rand");
            check("rand_position", bus.position, POS_W'(m_pos));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
